// File: rtl/dm_pkg.sv
// Shared constants and FSM encoding for the two-port data-memory arbiter.
package dm_pkg;

    localparam int DATA_W        = 32;
    localparam int DEPTH_DEF     = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Word address falls inside the data memory.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                           input logic [DATA_W-1:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin selector with a lock override for the previous owner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_hold,
    output logic       winner
);

    // Locked owner first, then alternate on ties, else the lone requester.
    always_comb begin
        winner = 1'b0;
        if (lock_hold) begin
            winner = last;
        end else if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates a CPU port (m0) and a DMA/loader port (m1) onto one data memory.
// Each accepted request takes one ACCESS cycle and one RESP cycle.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int                BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0]     BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [DATA_W-1:0] DEPTH_W    = DATA_W'(DEPTH);

    state_t              state_r;
    logic                last_r;
    logic                owner_r;
    logic                we_r;
    logic [BW-1:0]       burst_r;
    logic [DATA_W-1:0]   mem_a_r;
    logic [DATA_W-1:0]   mem_wd_r;
    logic                mem_we_r;
    logic [DATA_W-1:0]   rd_r;
    logic [1:0]          rvalid_r;
    logic [1:0]          err_r;

    logic [1:0]          req_s;
    logic [1:0]          lock_s;
    logic                can_grant_s;
    logic                lock_hold_s;
    logic                winner_s;
    logic [1:0]          gnt_s;
    logic                accept_s;
    logic                sel_we_s;
    logic [DATA_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wd_s;
    logic                range_ok_s;
    logic [BW-1:0]       burst_nxt_s;

    assign req_s       = {m1_req, m0_req};
    assign lock_s      = {m1_lock, m0_lock};
    assign can_grant_s = (state_r == ST_IDLE) || (state_r == ST_RESP);
    assign lock_hold_s = req_s[last_r] & lock_s[last_r] & (burst_r < BURST_LAST);
    assign accept_s    = |gnt_s;
    assign sel_we_s    = winner_s ? m1_we   : m0_we;
    assign sel_addr_s  = winner_s ? m1_addr : m0_addr;
    assign sel_wd_s    = winner_s ? m1_wd   : m0_wd;
    assign range_ok_s  = addr_in_range(mem_a_r, DEPTH_W);

    rr_arb2 u_rr_arb2 (
        .req       (req_s),
        .last      (last_r),
        .lock_hold (lock_hold_s),
        .winner    (winner_s)
    );

    // Grant the winner while the memory path is free (IDLE or RESP).
    always_comb begin
        gnt_s = 2'b00;
        if (can_grant_s && req_s[winner_s]) begin
            gnt_s = winner_s ? 2'b10 : 2'b01;
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Burst counter grows only while a locked owner keeps winning; saturates at the limit.
    always_comb begin
        burst_nxt_s = '0;
        if ((winner_s == last_r) && lock_s[winner_s]) begin
            if (burst_r < BURST_LAST) begin
                burst_nxt_s = burst_r + BW'(1);
            end else begin
                burst_nxt_s = burst_r;
            end
        end else begin
            burst_nxt_s = '0;
        end
    end

    // Main FSM: accept in IDLE/RESP, one memory cycle in ACCESS, response pulse in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;
            owner_r  <= 1'b0;
            we_r     <= 1'b0;
            burst_r  <= '0;
            mem_a_r  <= '0;
            mem_wd_r <= '0;
            mem_we_r <= 1'b0;
            rd_r     <= '0;
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    rvalid_r <= 2'b00;
                    err_r    <= 2'b00;
                    if (accept_s) begin
                        owner_r  <= winner_s;
                        last_r   <= winner_s;
                        burst_r  <= burst_nxt_s;
                        we_r     <= sel_we_s;
                        mem_a_r  <= sel_addr_s;
                        mem_wd_r <= sel_wd_s;
                        mem_we_r <= sel_we_s & addr_in_range(sel_addr_s, DEPTH_W);
                        state_r  <= ST_ACCESS;
                    end else begin
                        mem_we_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_we_r <= 1'b0;
                    rd_r     <= (we_r || !range_ok_s) ? '0 : mem_rd;
                    rvalid_r <= owner_r ? 2'b10 : 2'b01;
                    err_r    <= owner_r ? {!range_ok_s, 1'b0} : {1'b0, !range_ok_s};
                    state_r  <= ST_RESP;
                end
                default: begin
                    mem_we_r <= 1'b0;
                    rvalid_r <= 2'b00;
                    err_r    <= 2'b00;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt    = gnt_s[0];
    assign m1_gnt    = gnt_s[1];
    assign m0_rvalid = rvalid_r[0];
    assign m1_rvalid = rvalid_r[1];
    assign m0_err    = err_r[0];
    assign m1_err    = err_r[1];
    assign m0_rd     = rd_r;
    assign m1_rd     = rd_r;
    assign mem_we    = mem_we_r;
    assign mem_a     = mem_a_r;
    assign mem_wd    = mem_wd_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with an external memory model and a response scoreboard.
module tb_dm_arbiter;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wd, m0_rd;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wd, m1_rd;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic        init_done = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    dm_arbiter #(.DEPTH(DEPTH), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wd     (m0_wd),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rd     (m0_rd),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wd     (m1_wd),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rd     (m1_rd),
        .m1_err    (m1_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 10) ? 32'h55AA_55AA : (32'hA000_0000 | 32'(i));
    endfunction

    // External data memory: preloaded on the first edge, then written on mem_we.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (mem_we && (mem_a < 32'(DEPTH))) begin
            mem[mem_a[4:0]] <= mem_wd;
        end
    end

    assign mem_rd = (mem_a < 32'(DEPTH)) ? mem[mem_a[4:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compute the expected response for the port being granted now and push it.
    task automatic predict(input logic port);
        exp_t        e;
        logic        we;
        logic [31:0] addr, wd;
        we   = port ? m1_we   : m0_we;
        addr = port ? m1_addr : m0_addr;
        wd   = port ? m1_wd   : m0_wd;
        e.port = port;
        e.err  = (addr >= 32'(DEPTH));
        e.rd   = (we || e.err) ? 32'h0 : exp_mem[addr[4:0]];
        if (we && !e.err) exp_mem[addr[4:0]] = wd;
        sb.push_back(e);
    endtask

    task automatic check_rsp();
        exp_t       e;
        logic [1:0] rv;
        rv = {m1_rvalid, m0_rvalid};
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(rv), 32'h0);
        end else begin
            e = sb.pop_front();
            chk("rvalid", 32'(rv), e.port ? 32'h2 : 32'h1);
            chk("rd", e.port ? m1_rd : m0_rd, e.rd);
            chk("err", 32'(e.port ? m1_err : m0_err), 32'(e.err));
        end
    endtask

    task automatic single(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
        int   waited;
        logic exp_we;
        @(posedge clk); #1;
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wd = wd; m1_lock = 1'b0;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wd = wd; m0_lock = 1'b0;
        end
        waited = 0;
        @(negedge clk);
        while (!(port ? m1_gnt : m0_gnt) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("gnt_seen", 32'(port ? m1_gnt : m0_gnt), 32'h1);
        chk("gnt_other", 32'(port ? m0_gnt : m1_gnt), 32'h0);
        exp_we = we && (addr < 32'(DEPTH));
        predict(port);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_a", mem_a, addr);
        chk("rvalid_early", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        @(negedge clk);
        check_rsp();
    endtask

    // Requests are already driven; observe n grants against the expected port order.
    task automatic run_grants(input int n, input logic [7:0] order);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_rvalid || m1_rvalid) check_rsp();
            if (m0_gnt || m1_gnt) begin
                chk("one_gnt", 32'(m0_gnt & m1_gnt), 32'h0);
                chk($sformatf("order%0d", k), 32'(m1_gnt), 32'(order[k]));
                predict(m1_gnt);
                k++;
            end
        end
        chk("grants_done", 32'(k), 32'(n));
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) check_rsp();
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [1:0] seen_rv;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wd = 32'h0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wd = 32'h0; m1_lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        chk("rst_err", 32'({m1_err, m0_err}), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_rd", m0_rd, 32'h0);
        rst_n = 1'b1;

        // Both ports requesting continuously, no lock: strict alternation from m0.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
        run_grants(4, 8'b0000_1010);

        // Basic read, then write from m1 and read back from m0.
        single(1'b0, 1'b0, 32'd10, 32'h0);
        single(1'b1, 1'b1, 32'd3, 32'h1234_5678);
        single(1'b0, 1'b0, 32'd3, 32'h0);

        // m1 locked with m0 contending: four m1 grants, then m0.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd10; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd3;  m1_lock = 1'b1;
        run_grants(5, 8'b0000_1111);

        // Out-of-range write and read.
        single(1'b0, 1'b1, 32'd40, 32'hFFFF_0000);
        single(1'b0, 1'b0, 32'd40, 32'h0);

        // Reset in the middle of a write ACCESS.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wd = 32'hCAFE_F00D;
        waited = 0;
        @(negedge clk);
        while (!m0_gnt && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_gnt", 32'(m0_gnt), 32'h1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        chk("abort_mem_we_pre", 32'(mem_we), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'h0);
        chk("abort_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        chk("abort_mem_a", mem_a, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rv = 2'b00;
        repeat (3) begin
            @(negedge clk);
            seen_rv = seen_rv | {m1_rvalid, m0_rvalid};
        end
        chk("abort_no_rvalid", 32'(seen_rv), 32'h0);
        chk("addr5_kept", mem[5], exp_mem[5]);
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd5; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd6; m1_lock = 1'b0;
        run_grants(2, 8'b0000_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DEPTH, 32, number of words in the data memory; legal word addresses are 0..DEPTH-1.
REQ-002 Parameter MAX_BURST, 4, maximum consecutive grants to one locked requester.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 m0_req, m1_req  in  1  access request: m0 is the CPU port, m1 is the DMA/loader port.
REQ-006 m0_we, m1_we  in  1  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  in  32  word address.
REQ-008 m0_wd, m1_wd  in  32  write data.
REQ-009 m0_lock, m1_lock  in  1  request to keep ownership for back-to-back accesses.
REQ-010 m0_gnt, m1_gnt  out  1  request accepted this cycle.
REQ-011 m0_rvalid, m1_rvalid  out  1  one-cycle completion pulse.
REQ-012 m0_rd, m1_rd  out  32  read data; valid only with rvalid.
REQ-013 m0_err, m1_err  out  1  address out of range; valid only with rvalid.
REQ-014 mem_we  out  1  data memory write enable.
REQ-015 mem_a  out  32  data memory word address.
REQ-016 mem_wd  out  32  data memory write data.
REQ-017 mem_rd  in  32  data memory combinational read data.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-019 In IDLE or RESP, gnt_i SHALL assert combinationally when req_i is high and i wins arbitration; at most one gnt is high per cycle.
REQ-020 A request SHALL be accepted when req_i && gnt_i; addr, we, wd and owner id are registered; the next state is ACCESS.
REQ-021 With no accepted request, IDLE SHALL hold and RESP SHALL go to IDLE.
REQ-022 ACCESS SHALL last exactly one cycle, drive mem_a/mem_wd from the registered request, and capture mem_rd into the response register at its closing edge; the next state is RESP.
REQ-023 mem_we SHALL be 1 only in ACCESS with a registered write and addr < DEPTH.
REQ-024 RESP SHALL pulse the owner's rvalid for exactly one cycle with rd (reads; 0 for writes) and err = (addr >= DEPTH).
REQ-025 An out-of-range read SHALL return rd = 0 and err = 1; an out-of-range write SHALL not write memory.
REQ-026 Latency: gnt cycle N, ACCESS N+1, rvalid N+2; back-to-back issue every 2 cycles.
REQ-027 Arbitration SHALL be round-robin: on simultaneous requests, the port not most recently granted wins.
REQ-028 Lock: if the previous owner has lock high, req high, and burst_cnt < MAX_BURST-1, the owner SHALL win over the other port and burst_cnt increments.
REQ-029 Any grant to the other port, or a grant with lock low, SHALL reset burst_cnt to 0.
REQ-030 When burst_cnt reaches MAX_BURST-1, the next grant SHALL go to the other port if it is requesting.
REQ-031 Outside ACCESS, mem_we SHALL be 0 and mem_a/mem_wd SHALL hold their last values.
REQ-032 Requesters SHALL hold req, addr, we, wd stable until gnt; the arbiter does not check this.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, all gnt/rvalid/err/mem_we = 0, rd and mem_a/mem_wd = 0, burst_cnt = 0, and last-granted = m1 (so m0 wins the first tie).
REQ-034 Reset during ACCESS SHALL abort the access: no memory write and no rvalid is produced.

Structure
REQ-035 Package dm_pkg SHALL hold the DATA_W = 32 constant, the DEPTH default, and the FSM state encoding.
REQ-036 Two-way round-robin selection with lock override SHALL be the sub-module rr_arb2 (inputs req[1:0], last, lock_hold; output winner).

Verification
REQ-037 m0 reads addr 10 (memory word 10 = 0x55AA55AA) -> m0_gnt at N, m0_rvalid at N+2, m0_rd = 0x55AA55AA, err = 0.
REQ-038 m1 writes 0x12345678 to addr 3, then m0 reads addr 3 -> m0_rd = 0x12345678.
REQ-039 Both ports request continuously after reset, lock low -> grant order m0, m1, m0, m1.
REQ-040 m1 locked with continuous requests, m0 also requesting, MAX_BURST = 4 -> m1 granted 4 times, then m0.
REQ-041 m0 writes addr 40 -> mem_we stays 0, m0_err = 1 with rvalid; a following read of addr 40 returns rd = 0, err = 1.
REQ-042 rst_n low during an ACCESS write to addr 5 -> mem_we drops at once, addr 5 is unchanged, no rvalid is seen, and m0 wins the first tie after reset.
